acq_scheduler: RTL and testbench

//   Sequences one acquisition burst: runs the DUT clock-enable, waits a settle interval, then issues N ADC

---
 rtl/acq_scheduler_if.sv | 11 +
 rtl/acq_scheduler.sv | 170 +++++++++++++++++
 tb/tb_acq_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_scheduler_if.sv
// Sample stream between the acquisition scheduler and its consumer.
interface acq_scheduler_if #(
  parameter int unsigned DATA_W = 12
);
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/acq_scheduler.sv
// Acquisition burst sequencer: DUT clock-enable, settle wait, N ADC strobes,
// each sample forwarded through a 1-entry valid/ready buffer.
module acq_scheduler #(
  parameter int unsigned DIV_W  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  cfg_dut_div,
  input  logic [DIV_W-1:0]  cfg_adc_div,
  input  logic [CNT_W-1:0]  cfg_settle,
  input  logic [CNT_W-1:0]  cfg_nsamp,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  output logic              dut_ce,
  output logic              adc_ce,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  acq_scheduler_if.master   smp
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  dut_div_q, dut_div_d, adc_div_q, adc_div_d;
  logic [CNT_W-1:0]  settle_q, settle_d, nsamp_q, nsamp_d;
  logic [DIV_W-1:0]  dut_cnt_q, dut_cnt_d, adc_cnt_q, adc_cnt_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d, samp_cnt_q, samp_cnt_d;
  logic              dut_ce_q, dut_ce_d, adc_ce_q, adc_ce_d;
  logic              busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pop, dut_tick, adc_tick;

  // Strobes are registered: a tick seen now shows up as a strobe next cycle,
  // gated by the next state so no strobe leaks outside its active state.
  always_comb begin
    state_d      = state_q;
    dut_div_d    = dut_div_q;
    adc_div_d    = adc_div_q;
    settle_d     = settle_q;
    nsamp_d      = nsamp_q;
    dut_cnt_d    = dut_cnt_q;
    adc_cnt_d    = adc_cnt_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    ovr_d        = ovr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    pop          = valid_q & smp.sample_ready;
    dut_tick     = ((state_q == S_SETTLE) || (state_q == S_SAMPLE)) && (dut_cnt_q == dut_div_q);
    adc_tick     = (state_q == S_SAMPLE) && (adc_cnt_q == adc_div_q);

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          dut_div_d    = cfg_dut_div;
          adc_div_d    = cfg_adc_div;
          settle_d     = cfg_settle;
          nsamp_d      = cfg_nsamp;
          ovr_d        = 1'b0;
          dut_cnt_d    = '0;
          adc_cnt_d    = '0;
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        dut_cnt_d = dut_tick ? '0 : DIV_W'(dut_cnt_q + 1'b1);
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else if (dut_ce_q) begin
          settle_cnt_d = CNT_W'(settle_cnt_q + 1'b1);
          if (CNT_W'(settle_cnt_q + 1'b1) == settle_q) state_d = S_SAMPLE;
        end
        if (state_d == S_SAMPLE) adc_cnt_d = '0;
      end
      S_SAMPLE: begin
        dut_cnt_d = dut_tick ? '0 : DIV_W'(dut_cnt_q + 1'b1);
        adc_cnt_d = adc_tick ? '0 : DIV_W'(adc_cnt_q + 1'b1);
        if (nsamp_q == '0) begin
          state_d = S_DRAIN;
        end else if (adc_ce_q) begin
          samp_cnt_d = CNT_W'(samp_cnt_q + 1'b1);
          if (CNT_W'(samp_cnt_q + 1'b1) == nsamp_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (!valid_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // One-entry buffer: a pop in the same cycle frees the slot for the new sample
    if (pop) valid_d = 1'b0;
    if (adc_ce_q) begin
      if (!valid_q || pop) begin
        data_d  = adc_data;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (abort) begin
      state_d      = S_IDLE;
      valid_d      = 1'b0;
      ovr_d        = ovr_q;
      dut_cnt_d    = '0;
      adc_cnt_d    = '0;
      settle_cnt_d = '0;
      samp_cnt_d   = '0;
    end

    dut_ce_d = dut_tick && ((state_d == S_SETTLE) || (state_d == S_SAMPLE));
    adc_ce_d = adc_tick && (state_d == S_SAMPLE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dut_div_q    <= '0;
      adc_div_q    <= '0;
      settle_q     <= '0;
      nsamp_q      <= '0;
      dut_cnt_q    <= '0;
      adc_cnt_q    <= '0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      dut_ce_q     <= 1'b0;
      adc_ce_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dut_div_q    <= dut_div_d;
      adc_div_q    <= adc_div_d;
      settle_q     <= settle_d;
      nsamp_q      <= nsamp_d;
      dut_cnt_q    <= dut_cnt_d;
      adc_cnt_q    <= adc_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      dut_ce_q     <= dut_ce_d;
      adc_ce_q     <= adc_ce_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign dut_ce           = dut_ce_q;
  assign adc_ce           = adc_ce_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign overrun          = ovr_q;
  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler: strobe timing, scoreboarded samples,
// overrun, abort and asynchronous reset.
module tb_acq_scheduler;

  localparam int unsigned DIV_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 12;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [DIV_W-1:0]  cfg_dut_div, cfg_adc_div;
  logic [CNT_W-1:0]  cfg_settle, cfg_nsamp;
  logic              start, abort;
  logic [DATA_W-1:0] adc_data;
  logic              dut_ce, adc_ce, busy, done, overrun;

  acq_scheduler_if #(.DATA_W(DATA_W)) smp_if ();

  acq_scheduler #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .cfg_dut_div(cfg_dut_div), .cfg_adc_div(cfg_adc_div),
    .cfg_settle(cfg_settle), .cfg_nsamp(cfg_nsamp),
    .start(start), .abort(abort), .adc_data(adc_data),
    .dut_ce(dut_ce), .adc_ce(adc_ce), .busy(busy), .done(done), .overrun(overrun),
    .smp(smp_if.master)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base_cyc = 0;
  int ready_mode = 1;   // 0: never ready, 1: always ready, 2: ready only on adc_ce until all samples seen
  int exp_nsamp = 0;
  int adc_seen = 0;
  int done_cnt = 0;
  int done_rel = -1;
  int n_out = 0;
  bit model_ovr = 1'b0;
  int dut_rel[$];
  int adc_rel[$];
  logic [DATA_W-1:0] sbq[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Drives consumer ready and ADC data, logs strobes, runs the buffer scoreboard.
  always @(negedge clk_in) begin
    logic [DATA_W-1:0] exp_d;
    adc_data = DATA_W'($urandom);
    case (ready_mode)
      0:       smp_if.sample_ready = 1'b0;
      1:       smp_if.sample_ready = 1'b1;
      default: smp_if.sample_ready = adc_ce || (adc_seen >= exp_nsamp);
    endcase
    if (rst_n === 1'b1) begin
      if (dut_ce) dut_rel.push_back(cyc - base_cyc);
      if (adc_ce) begin
        adc_rel.push_back(cyc - base_cyc);
        adc_seen++;
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - base_cyc;
      end
      if (smp_if.sample_valid && smp_if.sample_ready) begin
        n_checks++;
        n_out++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sample_unexpected: got %0h, none expected", smp_if.sample_data);
        end else begin
          exp_d = sbq.pop_front();
          if (smp_if.sample_data !== exp_d) begin
            n_fail++;
            $display("FAIL sample_data: got %0h, expected %0h", smp_if.sample_data, exp_d);
          end
        end
      end
      if (adc_ce) begin
        if (sbq.size() == 0) sbq.push_back(adc_data);
        else model_ovr = 1'b1;
      end
    end
  end

  task automatic start_burst(input int dd, input int ad, input int st, input int ns, input int mode);
    @(negedge clk_in);
    cfg_dut_div = DIV_W'(dd);
    cfg_adc_div = DIV_W'(ad);
    cfg_settle  = CNT_W'(st);
    cfg_nsamp   = CNT_W'(ns);
    ready_mode  = mode;
    exp_nsamp   = ns;
    adc_seen = 0; done_cnt = 0; done_rel = -1; n_out = 0; model_ovr = 1'b0;
    dut_rel.delete(); adc_rel.delete(); sbq.delete();
    start = 1'b1;
    base_cyc = cyc + 1;
    @(negedge clk_in);
    start = 1'b0;
    // config changes after the latch must not affect the running burst
    cfg_dut_div = DIV_W'($urandom);
    cfg_adc_div = DIV_W'($urandom);
    cfg_settle  = CNT_W'($urandom);
    cfg_nsamp   = CNT_W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge clk_in);
    n_checks++;
    if (done_cnt == 0) begin n_fail++; $display("FAIL done_timeout: done count 0, expected 1"); end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic wait_adc(input int n);
    for (int i = 0; i < 2000 && adc_seen < n; i++) @(negedge clk_in);
    n_checks++;
    if (adc_seen < n) begin n_fail++; $display("FAIL adc_timeout: adc_ce count %0d, expected %0d", adc_seen, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_dut_div = '0; cfg_adc_div = '0; cfg_settle = '0; cfg_nsamp = '0;
    repeat (3) @(negedge clk_in);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    n_checks++; if (dut_ce !== 1'b0) begin n_fail++; $display("FAIL rst_dut_ce: got %b, expected 0", dut_ce); end
    n_checks++; if (adc_ce !== 1'b0) begin n_fail++; $display("FAIL rst_adc_ce: got %b, expected 0", adc_ce); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", done); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
    n_checks++; if (smp_if.sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", smp_if.sample_valid); end
    n_checks++; if (smp_if.sample_data !== '0) begin n_fail++; $display("FAIL rst_data: got %0h, expected 0", smp_if.sample_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_basic();
    int dd = 3, ad = 4, st = 2, ns = 3, last;
    start_burst(dd, ad, st, ns, 1);
    wait_done();
    last = st * (dd + 1) + 1 + ns * (ad + 1);
    n_checks++; if (dut_rel.size() < 2 || dut_rel[0] != dd + 1 || dut_rel[1] != 2 * (dd + 1)) begin
      n_fail++; $display("FAIL basic_dut_ce_time: got %p, expected first two at %0d,%0d", dut_rel, dd + 1, 2 * (dd + 1)); end
    n_checks++; if (dut_rel.size() != last / (dd + 1)) begin
      n_fail++; $display("FAIL basic_dut_ce_count: got %0d, expected %0d", dut_rel.size(), last / (dd + 1)); end
    n_checks++; if (adc_rel.size() != ns) begin
      n_fail++; $display("FAIL basic_adc_count: got %0d, expected %0d", adc_rel.size(), ns); end
    else for (int k = 0; k < ns; k++) begin
      n_checks++;
      if (adc_rel[k] != st * (dd + 1) + 1 + (k + 1) * (ad + 1)) begin
        n_fail++; $display("FAIL basic_adc_time[%0d]: got %0d, expected %0d", k, adc_rel[k], st * (dd + 1) + 1 + (k + 1) * (ad + 1)); end
    end
    n_checks++; if (n_out != ns) begin n_fail++; $display("FAIL basic_samples_out: got %0d, expected %0d", n_out, ns); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", done_cnt); end
    n_checks++; if (done_rel != last + 3) begin n_fail++; $display("FAIL basic_done_time: got %0d, expected %0d", done_rel, last + 3); end
    n_checks++; if (overrun !== model_ovr) begin n_fail++; $display("FAIL basic_overrun: got %b, expected %b", overrun, model_ovr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b, expected 0", busy); end
  endtask

  task automatic test_overrun();
    start_burst(3, 4, 2, 3, 0);
    wait_adc(3);
    repeat (6) @(negedge clk_in);
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL ovr_drain_done: got %0d, expected 0", done_cnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_drain_busy: got %b, expected 1", busy); end
    n_checks++; if (overrun !== 1'b1 || !model_ovr) begin n_fail++; $display("FAIL ovr_flag: got %b, expected 1", overrun); end
    ready_mode = 1;
    wait_done();
    n_checks++; if (n_out != 1) begin n_fail++; $display("FAIL ovr_samples_out: got %0d, expected 1", n_out); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ovr_done_count: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_zero();
    start_burst(0, 0, 0, 0, 1);
    wait_done();
    n_checks++; if (adc_rel.size() != 0) begin n_fail++; $display("FAIL zero_adc_count: got %0d, expected 0", adc_rel.size()); end
    n_checks++; if (dut_rel.size() != 1) begin n_fail++; $display("FAIL zero_dut_count: got %0d, expected 1", dut_rel.size()); end
    n_checks++; if (done_rel != 3) begin n_fail++; $display("FAIL zero_done_time: got %0d, expected 3", done_rel); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    start_burst(3, 4, 2, 3, 2);
    wait_done();
    n_checks++; if (overrun !== 1'b0 || model_ovr) begin n_fail++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
    n_checks++; if (n_out != 3) begin n_fail++; $display("FAIL b2b_samples_out: got %0d, expected 3", n_out); end
    n_checks++; if (done_rel != 27) begin n_fail++; $display("FAIL b2b_done_time: got %0d, expected 27", done_rel); end
  endtask

  task automatic test_abort();
    int d0, a0;
    start_burst(3, 4, 2, 3, 0);
    wait_adc(1);
    repeat (2) @(negedge clk_in);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    n_checks++; if (smp_if.sample_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b, expected 0", smp_if.sample_valid); end
    n_checks++; if (dut_ce !== 1'b0 || adc_ce !== 1'b0) begin n_fail++; $display("FAIL abort_strobes: got %b%b, expected 00", dut_ce, adc_ce); end
    sbq.delete();
    d0 = dut_rel.size(); a0 = adc_rel.size();
    repeat (30) @(negedge clk_in);
    n_checks++; if (dut_rel.size() != d0 || adc_rel.size() != a0) begin
      n_fail++; $display("FAIL abort_strobes_stop: got %0d/%0d, expected %0d/%0d", dut_rel.size(), adc_rel.size(), d0, a0); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d, expected 0", done_cnt); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk_in);
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b, expected 0", busy); end
    repeat (10) @(negedge clk_in);
    n_checks++; if (dut_rel.size() != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_idle: dut_ce %0d busy %b, expected %0d and 0", dut_rel.size(), busy, d0); end
  endtask

  task automatic test_reset_mid();
    start_burst(3, 4, 2, 3, 1);
    wait_adc(2);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, dut_ce, adc_ce, done, overrun, smp_if.sample_valid} !== 6'b0 || smp_if.sample_data !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy%b dce%b ace%b done%b ovr%b v%b d%0h, expected all 0",
                         busy, dut_ce, adc_ce, done, overrun, smp_if.sample_valid, smp_if.sample_data); end
    @(negedge clk_in);
    rst_n = 1'b1;
    sbq.delete();
    start_burst(1, 2, 1, 4, 1);
    wait_done();
    n_checks++; if (n_out != 4) begin n_fail++; $display("FAIL post_reset_samples: got %0d, expected 4", n_out); end
    n_checks++; if (adc_rel.size() != 4 || adc_rel[0] != 6) begin n_fail++; $display("FAIL post_reset_adc: got %p, expected 4 pulses first at 6", adc_rel); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL post_reset_done: got %0d, expected 1", done_cnt); end
  endtask

  initial begin
    smp_if.sample_ready = 1'b0;
    adc_data = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
